// File: rtl/gamma_bus_master.sv
// Driver end of the gamma bus: fills the 768-entry R/G/B gamma tables in gamma_fast
// either from a host byte stream or with an identity ramp, and samples core presence.
module gamma_bus_master (
  input  logic       clk_sys,
  input  logic       reset_n,
  inout  wire [21:0] gamma_bus,
  input  logic       enable,
  input  logic       load_start,
  input  logic       ramp_start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       present
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RAMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'd767;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        wr_q, wr_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        error_q, error_d;
  logic [1:0]  pres_q, pres_d;

  // Status outputs are plain decodes of the state register, so they never glitch.
  assign s_ready = (state_q == ST_LOAD);
  assign busy    = (state_q == ST_LOAD) || (state_q == ST_RAMP);
  assign done    = (state_q == ST_DONE);
  assign error   = error_q;
  assign present = pres_q[1];

  // Bit 21 belongs to the core; we only listen on it.
  assign gamma_bus[21]    = 1'bz;
  assign gamma_bus[20]    = clk_sys;
  assign gamma_bus[19:0]  = {en_q, wr_q, addr_q, data_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    error_d = error_q;
    en_d    = enable & ~busy;
    pres_d  = {pres_q[0], gamma_bus[21]};

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = 10'd0;
          error_d = 1'b0;
        end else if (ramp_start) begin
          state_d = ST_RAMP;
          cnt_d   = 10'd0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          data_d = s_data;
          cnt_d  = cnt_q + 10'd1;
          // A full table ends the load whether or not s_last came with it.
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else if (s_last) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RAMP: begin
        wr_d   = 1'b1;
        addr_d = cnt_q;
        data_d = cnt_q[7:0];
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 10'd0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 10'd0;
      data_q  <= 8'd0;
      error_q <= 1'b0;
      pres_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      pres_q  <= pres_d;
    end
  end

endmodule

// File: tb/tb_gamma_bus_master.sv
// Self-checking bench for gamma_bus_master: cycle table for handshakes and priority,
// hand sequences for full load, short stream, ramp and mid-load reset.
module tb_gamma_bus_master;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  wire [21:0] gamma_bus;
  logic       enable = 1'b0;
  logic       load_start = 1'b0;
  logic       ramp_start = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       pres_drv = 1'b0;
  logic       s_ready, busy, done, error, present;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int done_count = 0;

  assign gamma_bus[21] = pres_drv;

  gamma_bus_master dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .gamma_bus  (gamma_bus),
    .enable     (enable),
    .load_start (load_start),
    .ramp_start (ramp_start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .present    (present)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (gamma_bus[18] === 1'b1) wr_count++;
      if (done === 1'b1) done_count++;
    end
  end

  typedef struct {
    logic       ls, rs, sv, sl, pr;
    logic [7:0] sd;
    logic       e_rdy, e_busy, e_done, e_err, e_wr, e_en, e_pres;
    logic [9:0] e_addr;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic ls, input logic rs, input logic sv, input logic sl,
                              input logic pr, input logic [7:0] sd, input logic rdy,
                              input logic bsy, input logic dn, input logic err, input logic wr,
                              input logic en, input logic pres, input logic [9:0] addr,
                              input logic [7:0] data);
    vec_t v;
    v.ls = ls; v.rs = rs; v.sv = sv; v.sl = sl; v.pr = pr; v.sd = sd;
    v.e_rdy = rdy; v.e_busy = bsy; v.e_done = dn; v.e_err = err; v.e_wr = wr;
    v.e_en = en; v.e_pres = pres; v.e_addr = addr; v.e_data = data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int i, cyc, w0, d0;
    bit v;

    // Cycle script; enable is held high throughout.
    //            ls rs sv sl pr  sd      rdy bsy dn err wr en pr  addr    data
    vecs[0] = mk(0, 0, 0, 0, 0, 8'h00,  0,  0,  0, 0,  0, 1, 0, 10'd0, 8'h00);
    vecs[1] = mk(1, 1, 0, 0, 0, 8'h00,  1,  1,  0, 0,  0, 1, 0, 10'd0, 8'h00);
    vecs[2] = mk(0, 1, 1, 0, 0, 8'hA5,  1,  1,  0, 0,  1, 0, 0, 10'd0, 8'hA5);
    vecs[3] = mk(0, 0, 0, 0, 1, 8'h00,  1,  1,  0, 0,  0, 0, 0, 10'd0, 8'h00);
    vecs[4] = mk(0, 0, 1, 0, 1, 8'h3C,  1,  1,  0, 0,  1, 0, 1, 10'd1, 8'h3C);
    vecs[5] = mk(1, 0, 1, 1, 1, 8'h77,  0,  0,  1, 1,  1, 0, 1, 10'd2, 8'h77);
    vecs[6] = mk(0, 1, 0, 0, 1, 8'h00,  0,  0,  0, 1,  0, 1, 1, 10'd0, 8'h00);
    vecs[7] = mk(0, 0, 0, 0, 1, 8'h00,  0,  0,  0, 1,  0, 1, 1, 10'd0, 8'h00);

    // Reset state
    repeat (3) tick();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_present", present, 1'b0);
    chk("rst_bus", gamma_bus[19:0], 20'd0);
    chk("bus_clk_hi", gamma_bus[20], 1'b1);
    #5;
    chk("bus_clk_lo", gamma_bus[20], 1'b0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    enable = 1'b1;

    for (int r = 0; r < 8; r++) begin
      load_start = vecs[r].ls;
      ramp_start = vecs[r].rs;
      s_valid    = vecs[r].sv;
      s_last     = vecs[r].sl;
      s_data     = vecs[r].sd;
      pres_drv   = vecs[r].pr;
      tick();
      $display("[TB] row %0d rdy=%0b busy=%0b done=%0b err=%0b wr=%0b en=%0b pres=%0b",
               r, s_ready, busy, done, error, gamma_bus[18], gamma_bus[19], present);
      chk($sformatf("row%0d_ready", r), s_ready, vecs[r].e_rdy);
      chk($sformatf("row%0d_busy", r), busy, vecs[r].e_busy);
      chk($sformatf("row%0d_done", r), done, vecs[r].e_done);
      chk($sformatf("row%0d_error", r), error, vecs[r].e_err);
      chk($sformatf("row%0d_wr", r), gamma_bus[18], vecs[r].e_wr);
      chk($sformatf("row%0d_en", r), gamma_bus[19], vecs[r].e_en);
      chk($sformatf("row%0d_present", r), present, vecs[r].e_pres);
      if (vecs[r].e_wr) begin
        chk($sformatf("row%0d_addr", r), gamma_bus[17:8], vecs[r].e_addr);
        chk($sformatf("row%0d_data", r), gamma_bus[7:0], vecs[r].e_data);
      end
    end
    load_start = 1'b0; ramp_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;

    // Full 768-byte load with random valid gaps
    w0 = wr_count; d0 = done_count;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy", busy, 1'b1);
    i = 0; cyc = 0;
    while (i < 768 && cyc < 4000) begin
      v = ($urandom_range(0, 3) != 0);
      chk("load_ready", s_ready, 1'b1);
      s_valid = v;
      s_data  = 8'((i * 3) & 255);
      tick();
      cyc++;
      if (v) begin
        chk("load_wr", gamma_bus[18], 1'b1);
        chk("load_addr", gamma_bus[17:8], 32'(i));
        chk("load_data", gamma_bus[7:0], 32'((i * 3) & 255));
        chk("load_en", gamma_bus[19], 1'b0);
        i++;
      end else begin
        chk("load_gap_wr", gamma_bus[18], 1'b0);
      end
    end
    chk("load_count_reached", 32'(i), 32'd768);
    $display("[TB] full load: %0d bytes in %0d cycles", i, cyc);
    chk("load_done", done, 1'b1);
    chk("load_busy_end", busy, 1'b0);
    chk("load_ready_end", s_ready, 1'b0);
    chk("load_error", error, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    tick();
    s_valid = 1'b0;
    chk("load_extra_wr", gamma_bus[18], 1'b0);
    chk("load_done_once", done, 1'b0);
    chk("load_en_back", gamma_bus[19], 1'b1);
    chk("load_wr_total", 32'(wr_count - w0), 32'd768);
    chk("load_done_total", 32'(done_count - d0), 32'd1);

    // Short stream: s_last on byte 99
    w0 = wr_count;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      s_valid = 1'b1;
      s_last  = (k == 99);
      s_data  = 8'(k) ^ 8'h5A;
      tick();
      chk("short_wr", gamma_bus[18], 1'b1);
      chk("short_addr", gamma_bus[17:8], 32'(k));
      chk("short_data", gamma_bus[7:0], 32'(8'(k) ^ 8'h5A));
    end
    s_valid = 1'b0; s_last = 1'b0;
    $display("[TB] short stream: error=%0b done=%0b", error, done);
    chk("short_error", error, 1'b1);
    chk("short_done", done, 1'b1);
    chk("short_busy", busy, 1'b0);
    tick();
    chk("short_idle_wr", gamma_bus[18], 1'b0);
    chk("short_wr_total", 32'(wr_count - w0), 32'd100);

    // Ramp; its start clears the sticky error
    w0 = wr_count; d0 = done_count;
    ramp_start = 1'b1;
    tick();
    ramp_start = 1'b0;
    chk("ramp_err_clr", error, 1'b0);
    chk("ramp_busy", busy, 1'b1);
    for (int k = 0; k < 768; k++) begin
      tick();
      chk("ramp_wr", gamma_bus[18], 1'b1);
      chk("ramp_addr", gamma_bus[17:8], 32'(k));
      chk("ramp_data", gamma_bus[7:0], 32'(k & 255));
      if (k == 300) chk("ramp_300", gamma_bus[7:0], 32'd44);
      if (k == 767) begin
        chk("ramp_767", gamma_bus[7:0], 32'd255);
        chk("ramp_done", done, 1'b1);
        chk("ramp_busy_end", busy, 1'b0);
      end
    end
    tick();
    chk("ramp_after_wr", gamma_bus[18], 1'b0);
    chk("ramp_en_back", gamma_bus[19], 1'b1);
    chk("ramp_wr_total", 32'(wr_count - w0), 32'd768);
    chk("ramp_done_total", 32'(done_count - d0), 32'd1);
    $display("[TB] ramp: %0d writes", wr_count - w0);

    // Asynchronous reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h11;
    tick();
    tick();
    chk("pre_rst_wr", gamma_bus[18], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr", gamma_bus[18], 1'b0);
    chk("mid_rst_bus", gamma_bus[19:0], 20'd0);
    chk("mid_rst_present", present, 1'b0);
    s_valid = 1'b0;
    tick();
    chk("in_rst_en", gamma_bus[19], 1'b0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_en", gamma_bus[19], 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_pres0", present, 1'b0);
    tick();
    chk("post_rst_pres1", present, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gamma_bus_master.md
# gamma_bus_master

Driver end of the 22-bit gamma bus that feeds `gamma_fast` in the core. It owns the bus clock, enable, write strobe, address and data lines. It fills the 768-entry R/G/B gamma tables in one of two ways: from a host byte stream (HPS file load), or with a built-in identity ramp. Bus bit 21 is the core's presence flag; this block releases it and samples it.

## Interface
Parameters:
- none (table size fixed: 768 entries, 3 × 256)

Ports:
- `clk_sys` in 1: single clock. Also driven onto `gamma_bus[20]`.
- `reset_n` in 1: asynchronous, active-low reset.
- `gamma_bus` inout 22
  - [21] released (z), sampled as presence.
  - [20] `clk_sys`
  - [19] gamma_en
  - [18] gamma_wr
  - [17:8] write address
  - [7:0] write value
- `enable` in 1: user gamma-enable request (level).
- `load_start` in 1: single-cycle pulse; starts a stream load.
- `ramp_start` in 1: single-cycle pulse; starts an identity fill.
- `s_data` in 8: stream byte.
- `s_valid` in 1: stream byte valid.
- `s_last` in 1: marks the final byte of the stream.
- `s_ready` out 1: block accepts a byte when `s_valid & s_ready`.
- `busy` out 1: high while in LOAD or RAMP.
- `done` out 1: one-cycle pulse at the end of a load or ramp.
- `error` out 1: sticky short-stream flag; cleared by the next accepted start.
- `present` out 1: synchronized `gamma_bus[21]`.

## Operation
- States: IDLE, LOAD, RAMP, DONE. A 10-bit counter `cnt` holds the next write address.
- IDLE:
  - `load_start` → LOAD, `cnt`=0, `error`=0.
  - Else `ramp_start` → RAMP, `cnt`=0, `error`=0.
  - Both asserted in the same cycle: LOAD wins.
- Starts are ignored outside IDLE.
- LOAD:
  - `s_ready`=1, taken directly from the state register.
  - Each accepted byte issues one bus write: address = `cnt`, value = `s_data`. Then `cnt`++.
  - Byte accepted with `cnt`=767 → DONE. `s_last` on this byte is optional and ignored.
  - `s_last` accepted with `cnt`<767 → `error`=1, DONE. That byte is still written. Entries above it keep their previous contents.
  - `s_valid` low: no write, `cnt` holds. There is no timeout.
- RAMP:
  - One write per cycle: address = `cnt`, value = `cnt[7:0]`.
  - Write with `cnt`=767 → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- gamma_en is registered as `enable & ~busy`. It drops while tables are rewritten so no mixed curve is displayed, and restores automatically afterwards.
- `present`: two-flop synchronizer on `gamma_bus[21]`. Loads and ramps run regardless of `present`.
- Address map on the bus: 0–255 = R, 256–511 = G, 512–767 = B. Addresses 768–1023 are never issued.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `s_ready`=0, `busy`=0, `done`=0, `error`=0, `present`=0.
  - `gamma_bus[19:0]`=0. Bit 20 follows `clk_sys` at all times.
- Bus write latency: byte accepted at edge N → gamma_wr=1 with its address and value during cycle N+1, exactly one cycle per write.
- All bus fields are registered and change only on `clk_sys` rising edges. The receiver samples them on the next edge.
- `s_ready` falls in the cycle after the 768th acceptance, so a 769th byte is never accepted.
- The last write and `done` share the same cycle, N+1. `busy` falls in that cycle too.
- gamma_en lags `enable`/`busy` by one cycle.
- RAMP: 768 consecutive gamma_wr cycles.
- Reset mid-operation: all outputs return to reset values immediately. The partially written table stays in the core, and gamma_en=0 until reset is released.

## Test plan
- Reset: assert `reset_n`=0 mid-LOAD → `s_ready`/`busy`/gamma_wr drop immediately; bus[19:0]=0.
- Full load: `load_start`, then 768 bytes with value = (i*3)&255 and random `s_valid` gaps → exactly 768 gamma_wr pulses, addresses 0..767 in order, values match; one `done` pulse; `error`=0; a further offered byte is not accepted.
- Short stream: 100 bytes with `s_last` on byte 99 → 100 writes (addresses 0..99), `error`=1, `done` pulse. The next `ramp_start` clears `error`.
- Ramp: `ramp_start` → 768 back-to-back writes, address 300 carries value 44, address 767 carries value 255; `done` at the cycle of the last write.
- Enable gating: `enable`=1 in IDLE → gamma_en=1 one cycle later. During a load gamma_en=0; it returns to 1 in the cycle after `done`.
- Start priority and presence: `load_start` and `ramp_start` together → LOAD. `ramp_start` during a load is ignored. `gamma_bus[21]` driven 1 → `present`=1 after 2 cycles.
